// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT capture path.
// The spectrogram address mapper imports the same package.
package fft_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int OUT_WIDTH  = 16;
  localparam int FFT_SIZE   = 256;
  localparam int NO_FFTS    = 50;

  localparam int HALF_SIZE = FFT_SIZE / 2;
  localparam int BIN_W     = $clog2(FFT_SIZE);
  localparam int FRAME_W   = $clog2(NO_FFTS);
  localparam int SAMPLE_W  = $clog2(HALF_SIZE);
  localparam int TAG_W     = FRAME_W + SAMPLE_W;

  localparam logic [BIN_W-1:0]   LAST_BIN   = BIN_W'(FFT_SIZE - 1);
  localparam logic [BIN_W-1:0]   HALF_BIN   = BIN_W'(HALF_SIZE);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NO_FFTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/power_sq.sv
// Two-stage |X|^2 pipeline: stage 1 registers re^2 and im^2, stage 2
// registers the sum after shift and saturation, with the tag travelling alongside.
module power_sq #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int MAG_SHIFT  = 17,
  parameter int TAG_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  input  logic signed [DATA_WIDTH-1:0] re_i,
  input  logic signed [DATA_WIDTH-1:0] im_i,
  input  logic        [TAG_W-1:0]      tag_i,
  output logic                         out_valid_o,
  output logic        [OUT_WIDTH-1:0]  data_o,
  output logic        [TAG_W-1:0]      tag_o
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int PW     = PROD_W + 1;
  localparam logic [PW-1:0] SAT_MAX = {{(PW - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  logic signed [PROD_W-1:0] re_ext, im_ext;
  logic        [PROD_W-1:0] sq_re_d, sq_im_d, sq_re_q, sq_im_q;
  logic                     valid1_q;
  logic        [TAG_W-1:0]  tag1_q;
  logic        [PW-1:0]     sum_w, shifted_w;
  logic        [OUT_WIDTH-1:0] data_d;

  always_comb begin
    re_ext  = PROD_W'(re_i);
    im_ext  = PROD_W'(im_i);
    sq_re_d = re_ext * re_ext;
    sq_im_d = im_ext * im_ext;
  end

  // Squares are non-negative, so the sum is formed unsigned with one carry bit.
  always_comb begin
    sum_w     = {1'b0, sq_re_q} + {1'b0, sq_im_q};
    shifted_w = sum_w >> MAG_SHIFT;
    data_d    = (shifted_w > SAT_MAX) ? {OUT_WIDTH{1'b1}} : shifted_w[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q    <= 1'b0;
      tag1_q      <= '0;
      sq_re_q     <= '0;
      sq_im_q     <= '0;
      out_valid_o <= 1'b0;
      data_o      <= '0;
      tag_o       <= '0;
    end else begin
      valid1_q    <= in_valid_i;
      tag1_q      <= tag_i;
      sq_re_q     <= sq_re_d;
      sq_im_q     <= sq_im_d;
      out_valid_o <= valid1_q;
      data_o      <= data_d;
      tag_o       <= tag1_q;
    end
  end

endmodule

// File: rtl/fft_bin_sequencer.sv
// Frame-aligned capture of FFT bins: keeps the lower half of each frame,
// tags each kept bin with {frame, bin} and forwards its power for RAM writes.
module fft_bin_sequencer
  import fft_pkg::*;
#(
  parameter int MAG_SHIFT = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_re,
  input  logic [DATA_WIDTH-1:0] s_im,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  wr_en,
  output logic [OUT_WIDTH-1:0]  wr_data,
  output logic [FRAME_W-1:0]    fft_idx,
  output logic [SAMPLE_W-1:0]   sample_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err,
  output logic [1:0]            dbg_state_o
);

  // Stream handshake: s_valid qualifies s_re/s_im/s_last for exactly one
  // cycle; there is no ready, so every valid beat is consumed or dropped.
  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 pipe_valid;
  logic [TAG_W-1:0]     pipe_tag, out_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      bin_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bin_q   <= bin_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bin_d      = bin_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    pipe_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SYNC;
          frame_d = '0;
        end
      end
      ST_SYNC: begin
        if (s_valid && s_last) begin
          state_d = ST_CAPTURE;
          bin_d   = '0;
        end
      end
      ST_CAPTURE: begin
        if (s_valid) begin
          pipe_valid = (bin_q < HALF_BIN);
          if (bin_q == LAST_BIN) begin
            bin_d = '0;
            if (!s_last) begin
              err_d   = 1'b1;
              state_d = ST_SYNC;
            end else if (frame_q == LAST_FRAME) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end else if (s_last) begin
            // Short frame: restart the same row so the next frame overwrites it.
            err_d = 1'b1;
            bin_d = '0;
          end else begin
            bin_d = bin_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pipe_tag = {frame_q, bin_q[SAMPLE_W-1:0]};

  power_sq #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .MAG_SHIFT (MAG_SHIFT),
    .TAG_W     (TAG_W)
  ) u_power_sq (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (pipe_valid),
    .re_i       (s_re),
    .im_i       (s_im),
    .tag_i      (pipe_tag),
    .out_valid_o(wr_en),
    .data_o     (wr_data),
    .tag_o      (out_tag)
  );

  assign fft_idx     = out_tag[TAG_W-1:SAMPLE_W];
  assign sample_idx  = out_tag[SAMPLE_W-1:0];
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign frame_err   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fft_bin_sequencer.sv
// Directed bench for fft_bin_sequencer: two instances (shift 17 and shift 0)
// share one input stream; every write is checked against an expected queue.
module tb_fft_bin_sequencer;
  import fft_pkg::*;

  localparam int W = FRAME_W + SAMPLE_W + OUT_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [DATA_WIDTH-1:0] s_re = '0;
  logic [DATA_WIDTH-1:0] s_im = '0;
  logic                  s_valid = 1'b0;
  logic                  s_last = 1'b0;

  logic                  wr_en0, wr_en1, busy0, busy1, done0, done1, err0, err1;
  logic [OUT_WIDTH-1:0]  wr_data0, wr_data1;
  logic [FRAME_W-1:0]    fft_idx0, fft_idx1;
  logic [SAMPLE_W-1:0]   sample_idx0, sample_idx1;
  logic [1:0]            state0, state1;

  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  fft_bin_sequencer #(.MAG_SHIFT(17)) dut0 (
    .clk(clk), .rst(rst), .start(start), .s_re(s_re), .s_im(s_im),
    .s_valid(s_valid), .s_last(s_last), .wr_en(wr_en0), .wr_data(wr_data0),
    .fft_idx(fft_idx0), .sample_idx(sample_idx0), .busy(busy0), .done(done0),
    .frame_err(err0), .dbg_state_o(state0)
  );

  fft_bin_sequencer #(.MAG_SHIFT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .s_re(s_re), .s_im(s_im),
    .s_valid(s_valid), .s_last(s_last), .wr_en(wr_en1), .wr_data(wr_data1),
    .fft_idx(fft_idx1), .sample_idx(sample_idx1), .busy(busy1), .done(done1),
    .frame_err(err1), .dbg_state_o(state1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [OUT_WIDTH-1:0] pw(input int re, input int im, input int sh);
    longint p;
    p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    p = p >> sh;
    if (p > 65535) p = 65535;
    return OUT_WIDTH'(p);
  endfunction

  // Bins 0..3 carry hand-picked corner values; the rest follow a ramp.
  function automatic int data_re(input int f, input int b);
    case (b)
      0: return -32768;
      1: return 0;
      2: return 300;
      3: return 32767;
      default: return b * 100 - 12800 + f;
    endcase
  endfunction

  function automatic int data_im(input int f, input int b);
    case (b)
      0: return -32768;
      1: return 0;
      2: return 400;
      3: return -32768;
      default: return f * 600 - 15000;
    endcase
  endfunction

  task automatic push_exp(input int f, input int b);
    int re, im;
    re = data_re(f, b);
    im = data_im(f, b);
    exp0_q.push_back({FRAME_W'(f), SAMPLE_W'(b), pw(re, im, 17)});
    exp1_q.push_back({FRAME_W'(f), SAMPLE_W'(b), pw(re, im, 0)});
  endtask

  task automatic beat(input int re, input int im, input bit last);
    s_re    = DATA_WIDTH'(re);
    s_im    = DATA_WIDTH'(im);
    s_valid = 1'b1;
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends bins b0..b_end-1 of frame f with occasional gaps; s_last on the final beat if asked.
  task automatic send_frame(input int f, input int b0, input int b_end, input bit with_last, input bit capture);
    for (int b = b0; b < b_end; b++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      if (capture && b < HALF_SIZE) push_exp(f, b);
      beat(data_re(f, b), data_im(f, b), with_last && (b == b_end - 1));
    end
  endtask

  always @(negedge clk) begin
    if (wr_en0) begin
      wr_cnt++;
      if (exp0_q.size() == 0) check("unexpected_wr0", 1, 0);
      else check("wr0", {fft_idx0, sample_idx0, wr_data0}, exp0_q.pop_front());
    end
    if (wr_en1) begin
      if (exp1_q.size() == 0) check("unexpected_wr1", 1, 0);
      else check("wr1", {fft_idx1, sample_idx1, wr_data1}, exp1_q.pop_front());
    end
    if (done0) done_cnt++;
  end

  initial begin
    // Reset values
    idle(3);
    check("rst_wr_en", wr_en0, 0);
    check("rst_wr_data", wr_data0, 0);
    check("rst_fft_idx", fft_idx0, 0);
    check("rst_sample_idx", sample_idx0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_frame_err", err0, 0);
    rst = 1'b0;
    idle(2);

    // Beats in IDLE are ignored
    send_frame(0, 0, 10, 1, 0);
    check("idle_busy", busy0, 0);

    // Sync: 100 beats without s_last, then the aligning s_last
    start = 1'b1;
    idle(1);
    start = 1'b0;
    check("start_state", state0, ST_SYNC);
    check("start_busy", busy0, 1);
    send_frame(0, 0, 101, 1, 0);
    check("sync_state", state0, ST_CAPTURE);
    check("sync_no_writes", wr_cnt, 0);

    // Frame 0, bin 0 observed directly two edges after acceptance
    push_exp(0, 0);
    beat(data_re(0, 0), data_im(0, 0), 0);
    push_exp(0, 1);
    beat(data_re(0, 1), data_im(0, 1), 0);
    check("first_wr_en", wr_en0, 1);
    check("first_fft_idx", fft_idx0, 0);
    check("first_sample_idx", sample_idx0, 0);
    check("pow_neg_full_shift17", wr_data0, 16384);
    check("pow_neg_full_shift0_sat", wr_data1, 65535);
    push_exp(0, 2);
    beat(data_re(0, 2), data_im(0, 2), 0);
    check("pow_zero", wr_data0, 0);
    push_exp(0, 3);
    beat(data_re(0, 3), data_im(0, 3), 0);
    check("pow_300_400_shift0_sat", wr_data1, 65535);
    idle(1);
    check("pow_32767_neg32768", wr_data0, 16383);
    send_frame(0, 4, FFT_SIZE, 1, 1);

    // Frames 1..2; start held high across frame 2 must have no effect
    send_frame(1, 0, FFT_SIZE, 1, 1);
    start = 1'b1;
    send_frame(2, 0, FFT_SIZE, 1, 1);
    start = 1'b0;
    check("start_while_busy", state0, ST_CAPTURE);

    // Early s_last at bin 99 of frame 3, then frame 3 is redone
    send_frame(3, 0, 100, 1, 1);
    check("early_last_err", err0, 1);
    check("early_last_state", state0, ST_CAPTURE);
    idle(1);
    check("early_last_err_pulse", err0, 0);
    send_frame(3, 0, FFT_SIZE, 1, 1);

    // Missing s_last at bin 255 of frame 4: back to SYNC, frame index kept
    send_frame(4, 0, FFT_SIZE, 0, 1);
    check("missing_last_err", err0, 1);
    check("missing_last_state", state0, ST_SYNC);
    send_frame(4, 0, 20, 1, 0);
    check("resync_state", state0, ST_CAPTURE);
    for (int f = 4; f < NO_FFTS; f++) send_frame(f, 0, FFT_SIZE, 1, 1);
    check("done_pulse", done0, 1);
    check("done_busy", busy0, 0);
    idle(4);
    check("done_single", done0, 0);
    check("done_count", done_cnt, 1);
    check("write_count", wr_cnt, 6400 + 100 + 128);
    check("exp0_drained", exp0_q.size(), 0);
    check("exp1_drained", exp1_q.size(), 0);

    // Reset with a beat in the pipeline: nothing must come out
    start = 1'b1;
    idle(1);
    start = 1'b0;
    beat(1, 1, 1);
    beat(20000, 20000, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rstmid_wr_en", wr_en0, 0);
      check("rstmid_wr_data", wr_data0, 0);
      check("rstmid_idx", {fft_idx0, sample_idx0}, 0);
      check("rstmid_busy", busy0, 0);
      check("rstmid_flags", {done0, err0}, 0);
    end
    rst = 1'b0;
    idle(4);
    check("rstmid_no_writes", wr_cnt, 6628);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
